// File: rtl/uart_tx_arb.sv
// Two-source round-robin UART 8N1 transmitter with a per-frame restarted bit divider.
// Latency: byte accepted in cycle T, start bit on tx in T+1..T+BIT_CLKS, IDLE again at T+10*BIT_CLKS+1.
// Backpressure: reqN_ready only in IDLE for the arbitration winner; requests during a frame wait.
module uart_tx_arb #(
    parameter int BIT_CLKS = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int DW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_q, tx_nxt;
    logic          busy_q;
    logic          gid, gid_nxt;
    logic          last_grant, last_grant_nxt;
    logic          sel;
    logic          take;
    logic          bit_end;

    // Ties go to the requester that was not served last.
    always_comb begin
        sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) & req0_valid & ~sel & ~rst;
        req1_ready = (state == IDLE) & req1_valid &  sel & ~rst;
        take       = req0_ready | req1_ready;
        bit_end    = (div == DIV_LAST);
    end

    always_comb begin
        state_nxt      = state;
        div_nxt        = bit_end ? '0 : div + DW'(1);
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        tx_nxt         = tx_q;
        gid_nxt        = gid;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                div_nxt = '0;
                if (take) begin
                    state_nxt      = START;
                    shreg_nxt      = sel ? req1_data : req0_data;
                    gid_nxt        = sel;
                    last_grant_nxt = sel;
                    tx_nxt         = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = 3'd0;
                    tx_nxt      = shreg[0];
                    shreg_nxt   = {1'b0, shreg[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        tx_nxt      = shreg[0];
                        shreg_nxt   = {1'b0, shreg[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            gid        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            tx_q       <= tx_nxt;
            busy_q     <= (state_nxt != IDLE);
            gid        <= gid_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = gid;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: a frame-budget arbitration model predicts handshakes and
// bytes; monitors compare ready/busy/grant_id per cycle and decode tx frames from the line.
module tb_uart_tx_arb;

    localparam int BC    = 4;
    localparam int FRAME = 10 * BC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, tx, busy, grant_id;

    uart_tx_arb #(.BIT_CLKS(BC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int cyc; } gnt_t;
    gnt_t gq[$];
    int   bq[$];

    // Reference model: a frame occupies the line for FRAME cycles from its handshake.
    int m_free_at = 0, m_last = 1, m_gid = 0, m_hs = -1;
    int exp_busy = 0, exp_gid = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : model
        int s, d;
        exp_busy = (cyc > m_hs && cyc < m_free_at) ? 1 : 0;
        exp_gid  = m_gid;
        if (rst) begin
            if (exp_busy != 0 && bq.size() > 0) void'(bq.pop_back());
            m_free_at = cyc + 1;
            m_last    = 1;
            m_gid     = 0;
            m_hs      = -1;
        end else if (cyc >= m_free_at && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) s = 1 - m_last;
            else                          s = req1_valid ? 1 : 0;
            d = (s == 1) ? int'(req1_data) : int'(req0_data);
            gq.push_back('{s, cyc});
            bq.push_back(d);
            m_last    = s;
            m_gid     = s;
            m_hs      = cyc;
            m_free_at = cyc + FRAME;
        end
    end

    bit hs0 = 1'b0, hs1 = 1'b0;

    always @(negedge clk) begin : monitor
        int e0, e1;
        #1;
        chk("busy", int'(busy), exp_busy);
        chk("grant_id", int'(grant_id), exp_gid);
        if (exp_busy == 0) chk("tx_idle", int'(tx), 1);
        e0 = (gq.size() > 0 && gq[0].cyc == cyc && gq[0].id == 0) ? 1 : 0;
        e1 = (gq.size() > 0 && gq[0].cyc == cyc && gq[0].id == 1) ? 1 : 0;
        chk("req0_ready", int'(req0_ready), e0);
        chk("req1_ready", int'(req1_ready), e1);
        while (gq.size() > 0 && gq[0].cyc <= cyc) void'(gq.pop_front());
        hs0 = req0_valid & req0_ready;
        hs1 = req1_valid & req1_ready;
    end

    int         d_off = -1;
    logic [7:0] d_byte;

    always @(negedge clk) begin : decoder
        #1;
        if (rst) d_off = -1;
        else if (d_off < 0) begin
            if (tx == 1'b0) begin
                d_off  = 0;
                d_byte = 8'h00;
            end
        end else d_off++;
        if (d_off >= 0 && !rst) begin
            if (d_off == 2) chk("start_bit", int'(tx), 0);
            for (int k = 1; k <= 8; k++)
                if (d_off == k * BC + 2) d_byte[k-1] = tx;
            if (d_off == 9 * BC + 2) begin
                chk("stop_bit", int'(tx), 1);
                if (bq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame cyc=%0d got=0x%02h expected=none", cyc, d_byte);
                end else chk("frame_byte", int'(d_byte), bq.pop_front());
                d_off = -1;
            end
        end
    end

    // Requester sources: each sends its queued bytes in order, holding data until accepted.
    logic [7:0] src0[$], src1[$];
    bit         rnd = 1'b0;

    task automatic drive();
        if (hs0 && src0.size() > 0) void'(src0.pop_front());
        if (hs1 && src1.size() > 0) void'(src1.pop_front());
        req0_valid = (src0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        req1_valid = (src1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        req0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
        req1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            drive();
        end
    endtask

    initial begin
        // Reset idle, then reset held while req0 is already valid.
        rst = 1'b1;
        run(4);
        src0.push_back(8'h77);
        run(2);
        rst = 1'b0;
        run(FRAME + 5);
        // Single req0 byte.
        src0.push_back(8'hA5);
        run(FRAME + 5);
        // req1 alone, back to back.
        src1.push_back(8'h3C);
        src1.push_back(8'hC3);
        run(3 * FRAME);
        // Both continuously valid: alternation.
        src0.push_back(8'h11); src0.push_back(8'h11);
        src1.push_back(8'h22); src1.push_back(8'h22);
        run(5 * FRAME);
        // req0 arrives mid-frame while req1 keeps requesting.
        src1.push_back(8'h5A);
        src1.push_back(8'h6B);
        run(10);
        src0.push_back(8'h9C);
        run(4 * FRAME);
        // Reset during data bit 3 of a 0xFF frame, then both valid.
        src0.push_back(8'hFF);
        run(18);
        rst = 1'b1;
        src0.push_back(8'h5A);
        src1.push_back(8'h96);
        run(1);
        rst = 1'b0;
        run(3 * FRAME);
        // Randomized traffic with valid dropped at random while not accepted.
        rnd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (src0.size() < 3 && $urandom_range(0, 1) == 1) src0.push_back(8'($urandom));
            if (src1.size() < 3 && $urandom_range(0, 1) == 1) src1.push_back(8'($urandom));
            run($urandom_range(1, 60));
        end
        rnd = 1'b0;
        for (int i = 0; i < 40 * FRAME && (src0.size() > 0 || src1.size() > 0); i++) run(1);
        run(FRAME + 5);
        chk("sources_drained", src0.size() + src1.size(), 0);
        chk("grant_queue_empty", gq.size(), 0);
        chk("byte_queue_empty", bq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
UART 8N1 transmit engine shared between two byte sources, such as the MIPS store path and a debug/trace port. It arbitrates between the two requesters with round-robin fairness and accepts one byte per frame over a valid/ready handshake. It then sequences the start, data and stop bits onto a single tx line, using an internal per-bit clock divider. The divider restarts at every frame, so the start-bit timing is exact.

Parameters:
BIT_CLKS, 1042, clk cycles per serial bit; legal range >= 2; benches use 4.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a byte to send
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle
req1_valid  input  1  requester 1 has a byte to send
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress (state != IDLE)
grant_id  output  1  requester of the current or last accepted byte

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Reset wins over every other event.
- Reset values:
  - tx=1, busy=0, grant_id=0.
  - state=IDLE; bit counter and divider at 0.
  - last_grant=1, so the first tie goes to req0.
  - req0_ready and req1_ready are 0 during the reset cycle.
- States are IDLE, START, DATA and STOP.
- Arbitration (combinational, IDLE only):
  - Only reqN_valid high: sel=N.
  - Both valid: sel = ~last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & (sel==N) & ~rst.
  - At most one ready is high per cycle; both are 0 outside IDLE.
- Handshake: a transfer occurs when valid & ready in the same cycle. On that edge:
  - data is latched into the shift register;
  - grant_id and last_grant are set to N;
  - the divider is cleared and the state goes to START.
- Requester obligations: hold data stable while valid & ~ready. Deasserting valid without a transfer is legal and has no effect.
- START: tx=0 for BIT_CLKS cycles, then DATA.
- DATA: 8 bits, LSB first, each held BIT_CLKS cycles.
  - A 3-bit counter advances at each bit boundary.
  - After bit 7 the state goes to STOP.
- STOP: tx=1 for BIT_CLKS cycles, then IDLE.
- Output timing:
  - tx is registered and changes on the edge that enters each bit.
  - busy is registered and equals state != IDLE.
- Latency:
  - The handshake occurs in cycle T.
  - The start bit occupies cycles T+1 .. T+BIT_CLKS.
  - The stop bit ends at T+10*BIT_CLKS.
  - The state is IDLE in T+10*BIT_CLKS+1, where the next handshake is possible.
  - Minimum handshake spacing is 10*BIT_CLKS+1 cycles.
- Divider: counts 0 .. BIT_CLKS-1, width $clog2(BIT_CLKS). At BIT_CLKS-1 it is a bit boundary and wraps to 0.
- Requests arriving during a frame are ignored until IDLE; they are then arbitrated together with any other pending request.
- Reset mid-frame: the next cycle shows tx=1, busy=0, state IDLE and last_grant=1. The partial frame is abandoned and not resent.
- No starvation: a requester that holds valid waits at most one foreign frame.

Test Plan:
1. Reset with no valid: tx=1, busy=0, both ready=0 indefinitely. Then rst during IDLE with req0_valid=1: ready stays 0 in that cycle.
2. BIT_CLKS=4, single req0 byte 0xA5:
   - req0_ready is high for 1 cycle.
   - tx per 4-cycle bit is 0, 1,0,1,0,0,1,0,1, 1.
   - busy is high for 40 cycles; grant_id=0.
3. Both valid continuously with distinct bytes (0x11, 0x22): handshakes alternate req0, req1, req0, req1, spaced exactly 41 cycles apart; tx frames carry 0x11, 0x22, 0x11, 0x22.
4. Only req1 valid, back-to-back 0x3C, 0xC3: req1 is granted both times, 41 cycles apart; grant_id=1 throughout.
5. req1 is sending and req0 asserts valid mid-frame while req1 also keeps valid: the next grant is req0, and req1 is granted in the frame after that.
6. rst asserted during DATA bit 3 of a 0xFF frame, then both valid: the cycle after rst shows tx=1, busy=0. After rst releases, req0 is granted first and a complete frame follows.
